target_tx: RTL and testbench
============================

# target_tx

Serializer for the target side of the I3C HDR-DDR link. It drives SDA for target-originated words: the read preamble bit, data bytes, data-word parity, the CRC token and the CRC value. The DDR/CCC controller selects one mode at a time, and the block shifts that mode's bits out on every SCL edge strobe from the SCL generator. The block sits between the DDR/CCC controller, the register file, the CRC engine and the SDA handler's output path.

## Interface
Parameters:
- DATA_W, 8, data byte width (only 8 supported).

Ports:
- i_sys_clk  in  1  system clock.
- i_sys_rst  in  1  reset, synchronous, active-low.
- i_sclgen_scl_pos_edge  in  1  one-cycle strobe on SCL rise.
- i_sclgen_scl_neg_edge  in  1  one-cycle strobe on SCL fall.
- i_ddrccc_tx_en  in  1  transmit enable from the DDR/CCC controller.
- i_ddrccc_tx_mode  in  4  mode select (encodings below).
- i_ddrccc_pre_value  in  1  bit driven in preamble mode (0 = ACK, 1 = NACK/abort).
- i_regf_tx_data  in  8  next data byte; must be stable from before the first data-mode edge.
- i_crc_value  in  5  running CRC from the CRC engine.
- o_sdahnd_tx_sda  out  1  serialized SDA value.
- o_sdahnd_tx_oe  out  1  SDA drive enable.
- o_ddrccc_tx_mode_done  out  1  one-cycle pulse after a mode's last bit is driven.
- o_crc_data  out  8  byte just sent.
- o_crc_data_valid  out  1  one-cycle strobe qualifying o_crc_data.

## Operation
- Edge event: a system-clock cycle in which pos_edge or neg_edge is high. Both high in the same cycle count as one event.
- Mode encodings and lengths:
  - 0000 idle: SDA = 1.
  - 0001 preamble: 1 bit, i_ddrccc_pre_value.
  - 0010 data: 8 bits, MSB first.
  - 0100 parity: 2 bits, {P1,P0}.
  - 0101 token: 4 bits, 1100.
  - 0110 crc: 5 bits, i_crc_value MSB first.
  - 1001 special preamble: 2 bits, 01.
  - Any other encoding behaves as idle.
- Bit counter `count` (0..N-1). On each edge event with tx_en=1 in a non-idle mode:
  - SDA <= bit[count].
  - count <= count+1.
  - If count==N-1: count <= 0 and mode_done <= 1 in the next cycle.
- Data mode:
  - On the bit-0 event, i_regf_tx_data is captured into a shift register. Bit 0 is driven from i_regf_tx_data[7] directly.
  - On the bit-7 event, the full byte is written to D1 if first_byte_full=0, otherwise to D2, and first_byte_full toggles.
  - On the same event, o_crc_data <= byte and o_crc_data_valid pulses.
- Parity, computed over the D1/D2 pair:
  - P1 = XOR of bits 7,5,3,1 of D1 and D2.
  - P0 = XOR of bits 6,4,2,0 of D1 and D2, XOR 1.
  - Parity mode clears first_byte_full.
- Crc mode: i_crc_value is sampled once, at the bit-0 event, and held for all 5 bits.
- o_sdahnd_tx_oe = 1 whenever tx_en=1 and the mode is non-idle.
- tx_en=0:
  - count <= 0, SDA <= 1, oe <= 0, mode_done <= 0.
  - D1, D2 and first_byte_full are retained.
- Mode change: if i_ddrccc_tx_mode differs from the previous cycle's value, count <= 0 before that cycle's edge handling. An aborted mode never pulses done.
- Reset (i_sys_rst=0 at a clock edge):
  - SDA=1, oe=0, mode_done=0, crc_data_valid=0.
  - crc_data=0, count=0, D1=D2=0, first_byte_full=0, shift register=0.

## Timing
- SDA is registered: it changes on the cycle after the edge strobe.
- mode_done rises 1 cycle after the final bit's edge event and is high for exactly 1 cycle. The controller may change the mode in that cycle; the next edge event drives bit 0 of the new mode.
- o_crc_data_valid coincides with the data-mode done pulse.
- Edge strobes on consecutive cycles are legal; each advances one bit.
- Throughput: one bit per edge event; no internal stall.

## Configuration
- TARGET_TX_CRC_EN defined:
  - Token and crc modes behave as above.
  - o_crc_data and o_crc_data_valid are active.
- TARGET_TX_CRC_EN undefined:
  - Encodings 0101 and 0110 decode as idle (no done pulse).
  - o_crc_data_valid is tied 0 and o_crc_data is tied 0.
  - The CRC sampling logic is removed.

## Test plan
- Reset, then tx_en=1 in data mode with i_regf_tx_data=0xA5 and 8 alternating edges -> SDA 1,0,1,0,0,1,0,1; one done pulse; crc_data=0xA5 with valid.
- Data 0xA5, then data 0x3C, then parity mode, 2 edges -> SDA 0 then 1; first_byte_full=0 afterwards.
- Preamble mode, pre_value=0, 1 edge -> SDA 0, done 1 cycle later; then special preamble, 2 edges -> SDA 0,1.
- Token then crc with i_crc_value=5'b10110 -> SDA 1,1,0,0 then 1,0,1,1,0; two done pulses. With the macro undefined: SDA stays 1, oe=0, no done.
- Data mode, 3 edges, then tx_en=0 for 2 cycles, then re-enabled -> count restarts at 0 and the byte re-sends from the MSB. Same result for a mode switch after 3 bits.
- Assert i_sys_rst=0 mid-byte -> next cycle SDA=1, oe=0, done=0, D1=D2=0. pos and neg strobes in the same cycle -> only one bit advanced.

Source files
------------

// File: rtl/target_tx.sv
// target_tx: HDR-DDR target-side SDA serializer for preamble, data, parity, token and CRC words.
// Build option TARGET_TX_CRC_EN enables the token/CRC modes and the o_crc_data byte tap.
module target_tx #(
  parameter int DATA_W = 8
) (
  input  logic              i_sys_clk,
  input  logic              i_sys_rst,
  input  logic              i_sclgen_scl_pos_edge,
  input  logic              i_sclgen_scl_neg_edge,
  input  logic              i_ddrccc_tx_en,
  input  logic [3:0]        i_ddrccc_tx_mode,
  input  logic              i_ddrccc_pre_value,
  input  logic [DATA_W-1:0] i_regf_tx_data,
  input  logic [4:0]        i_crc_value,
  output logic              o_sdahnd_tx_sda,
  output logic              o_sdahnd_tx_oe,
  output logic              o_ddrccc_tx_mode_done,
  output logic [DATA_W-1:0] o_crc_data,
  output logic              o_crc_data_valid
);

  localparam logic [3:0] MODE_PRE   = 4'b0001;
  localparam logic [3:0] MODE_DATA  = 4'b0010;
  localparam logic [3:0] MODE_PAR   = 4'b0100;
  localparam logic [3:0] MODE_TOKEN = 4'b0101;
  localparam logic [3:0] MODE_CRC   = 4'b0110;
  localparam logic [3:0] MODE_SPRE  = 4'b1001;

  logic [3:0]        mode_prev;
  logic [2:0]        count;
  logic [2:0]        count_eff;
  logic [2:0]        last_idx;
  logic              mode_act;
  logic              edge_evt;
  logic              last_bit;
  logic              bit_val;
  logic              par1;
  logic              par0;
  logic [DATA_W-1:0] shift_reg;
  logic [DATA_W-1:0] d1;
  logic [DATA_W-1:0] d2;
  logic              first_byte_full;
  logic              sda;
  logic              oe;
  logic              done;

`ifdef TARGET_TX_CRC_EN
  logic [4:0]        crc_hold;
  logic [DATA_W-1:0] crc_data;
  logic              crc_valid;
`else
  logic              crc_unused;
  assign crc_unused = ^i_crc_value;
`endif

  assign edge_evt  = i_sclgen_scl_pos_edge | i_sclgen_scl_neg_edge;
  // A new mode always starts from bit 0, even if the old one was mid-word.
  assign count_eff = (i_ddrccc_tx_mode != mode_prev) ? 3'd0 : count;
  assign last_bit  = (count_eff == last_idx);

  assign par1 = d1[7] ^ d1[5] ^ d1[3] ^ d1[1] ^ d2[7] ^ d2[5] ^ d2[3] ^ d2[1];
  assign par0 = ~(d1[6] ^ d1[4] ^ d1[2] ^ d1[0] ^ d2[6] ^ d2[4] ^ d2[2] ^ d2[0]);

  always_comb begin
    mode_act = 1'b1;
    last_idx = 3'd0;
    bit_val  = 1'b1;
    case (i_ddrccc_tx_mode)
      MODE_PRE: begin
        last_idx = 3'd0;
        bit_val  = i_ddrccc_pre_value;
      end
      MODE_DATA: begin
        last_idx = 3'd7;
        bit_val  = (count_eff == 3'd0) ? i_regf_tx_data[DATA_W-1]
                                       : shift_reg[3'd7 - count_eff];
      end
      MODE_PAR: begin
        last_idx = 3'd1;
        bit_val  = count_eff[0] ? par0 : par1;
      end
      MODE_SPRE: begin
        last_idx = 3'd1;
        bit_val  = count_eff[0];
      end
`ifdef TARGET_TX_CRC_EN
      MODE_TOKEN: begin
        last_idx = 3'd3;
        bit_val  = ~count_eff[1];
      end
      MODE_CRC: begin
        last_idx = 3'd4;
        bit_val  = (count_eff == 3'd0) ? i_crc_value[4] : crc_hold[3'd4 - count_eff];
      end
`endif
      default: mode_act = 1'b0;
    endcase
  end

  // Stage p0: bit counter, SDA/OE registers and the D1/D2 parity pair
  always_ff @(posedge i_sys_clk) begin
    if (!i_sys_rst) begin
      mode_prev       <= 4'b0000;
      count           <= 3'd0;
      sda             <= 1'b1;
      oe              <= 1'b0;
      done            <= 1'b0;
      shift_reg       <= '0;
      d1              <= '0;
      d2              <= '0;
      first_byte_full <= 1'b0;
`ifdef TARGET_TX_CRC_EN
      crc_hold        <= 5'd0;
      crc_data        <= '0;
      crc_valid       <= 1'b0;
`endif
    end else begin
      mode_prev <= i_ddrccc_tx_mode;
      done      <= 1'b0;
`ifdef TARGET_TX_CRC_EN
      crc_valid <= 1'b0;
`endif
      if (!i_ddrccc_tx_en || !mode_act) begin
        count <= 3'd0;
        sda   <= 1'b1;
        oe    <= 1'b0;
      end else begin
        oe    <= 1'b1;
        count <= count_eff;
        if (edge_evt) begin
          sda   <= bit_val;
          count <= last_bit ? 3'd0 : count_eff + 3'd1;
          done  <= last_bit;
          if (i_ddrccc_tx_mode == MODE_DATA && count_eff == 3'd0) begin
            shift_reg <= i_regf_tx_data;
          end
          if (i_ddrccc_tx_mode == MODE_DATA && last_bit) begin
            if (first_byte_full) begin
              d2 <= shift_reg;
            end else begin
              d1 <= shift_reg;
            end
            first_byte_full <= ~first_byte_full;
`ifdef TARGET_TX_CRC_EN
            crc_data  <= shift_reg;
            crc_valid <= 1'b1;
`endif
          end
          if (i_ddrccc_tx_mode == MODE_PAR && last_bit) begin
            first_byte_full <= 1'b0;
          end
`ifdef TARGET_TX_CRC_EN
          if (i_ddrccc_tx_mode == MODE_CRC && count_eff == 3'd0) begin
            crc_hold <= i_crc_value;
          end
`endif
        end
      end
    end
  end

  assign o_sdahnd_tx_sda       = sda;
  assign o_sdahnd_tx_oe        = oe;
  assign o_ddrccc_tx_mode_done = done;
`ifdef TARGET_TX_CRC_EN
  assign o_crc_data            = crc_data;
  assign o_crc_data_valid      = crc_valid;
`else
  assign o_crc_data            = '0;
  assign o_crc_data_valid      = 1'b0;
`endif

endmodule

// File: tb/tb_target_tx.sv
// tb_target_tx: table vectors, directed corner sequences and randomized transactions for target_tx.
// Expectations adapt to whether TARGET_TX_CRC_EN is defined.
module tb_target_tx;

`ifdef TARGET_TX_CRC_EN
  localparam logic CRC_EN = 1'b1;
`else
  localparam logic CRC_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       pos = 1'b0;
  logic       neg = 1'b0;
  logic       tx_en = 1'b0;
  logic [3:0] mode = 4'd0;
  logic       pre_value = 1'b0;
  logic [7:0] tx_data = 8'd0;
  logic [4:0] crc_value = 5'd0;
  logic       sda;
  logic       oe;
  logic       done;
  logic [7:0] crc_data;
  logic       crc_valid;

  int         checks = 0;
  int         passes = 0;
  logic       prev_sda = 1'b1;
  logic [7:0] md1 = 8'd0;
  logic [7:0] md2 = 8'd0;
  logic       mfbf = 1'b0;

  typedef struct {
    logic [3:0] mode;
    logic       pre;
    logic [7:0] data;
    logic [4:0] crc;
    int         edges;
    logic [7:0] sda;
    logic       oe;
    logic       done;
    logic [7:0] crc_out;
    logic       crc_vld;
  } vec_t;

  vec_t tbl [9];

  target_tx #(.DATA_W(8)) dut (
    .i_sys_clk             (clk),
    .i_sys_rst             (rst),
    .i_sclgen_scl_pos_edge (pos),
    .i_sclgen_scl_neg_edge (neg),
    .i_ddrccc_tx_en        (tx_en),
    .i_ddrccc_tx_mode      (mode),
    .i_ddrccc_pre_value    (pre_value),
    .i_regf_tx_data        (tx_data),
    .i_crc_value           (crc_value),
    .o_sdahnd_tx_sda       (sda),
    .o_sdahnd_tx_oe        (oe),
    .o_ddrccc_tx_mode_done (done),
    .o_crc_data            (crc_data),
    .o_crc_data_valid      (crc_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick(input logic p, input logic n);
    pos = p;
    neg = n;
    @(posedge clk);
    #1;
    pos = 1'b0;
    neg = 1'b0;
  endtask

  // Reference model: the bit list each mode should put on SDA, MSB first, left-justified.
  function automatic void model_bits(input logic [3:0] m, input logic pre, input logic [7:0] d,
                                     input logic [4:0] c, output int n, output logic [7:0] b);
    logic p1;
    logic p0;
    p1 = (^(md1 & 8'hAA)) ^ (^(md2 & 8'hAA));
    p0 = ~((^(md1 & 8'h55)) ^ (^(md2 & 8'h55)));
    n = 0;
    b = 8'hFF;
    case (m)
      4'b0001: begin n = 1; b = {pre, 7'd0}; end
      4'b0010: begin n = 8; b = d; end
      4'b0100: begin n = 2; b = {p1, p0, 6'd0}; end
      4'b1001: begin n = 2; b = 8'b0100_0000; end
`ifdef TARGET_TX_CRC_EN
      4'b0101: begin n = 4; b = 8'b1100_0000; end
      4'b0110: begin n = 5; b = {c, 3'd0}; end
`endif
      default: begin n = 0; b = 8'hFF; end
    endcase
  endfunction

  function automatic void model_commit(input logic [3:0] m, input logic [7:0] d);
    if (m == 4'b0010) begin
      if (!mfbf) md1 = d;
      else md2 = d;
      mfbf = ~mfbf;
    end else if (m == 4'b0100) begin
      mfbf = 1'b0;
    end
  endfunction

  // One mode transaction; limit >= 0 stops early (aborted word), kind < 0 picks random strobes.
  task automatic do_txn(input logic [3:0] m, input logic pre, input logic [7:0] d,
                        input logic [4:0] c, input int limit, input int maxgap, input int kind);
    int n;
    int k;
    int r;
    int gaps;
    logic [7:0] b;
    logic exp;
    model_bits(m, pre, d, c, n, b);
    mode = m;
    pre_value = pre;
    tx_data = d;
    crc_value = c;
    tx_en = 1'b1;
    k = (n == 0) ? 2 : ((limit >= 0 && limit < n) ? limit : n);
    for (int i = 0; i < k; i++) begin
      gaps = $urandom_range(maxgap, 0);
      for (int g = 0; g < gaps; g++) begin
        tick(1'b0, 1'b0);
        check("gap_sda", sda, (n == 0) ? 1'b1 : prev_sda);
        check("gap_oe", oe, n > 0);
        check("gap_done", done, 1'b0);
      end
      r = (kind < 0) ? int'($urandom_range(2, 0)) : kind;
      tick(r != 1, r != 0);
      if (i == 0) begin
        tx_data = 8'($urandom);
        crc_value = 5'($urandom);
      end
      exp = (n == 0) ? 1'b1 : b[7-i];
      check("sda", sda, exp);
      check("oe", oe, n > 0);
      check("done", done, n > 0 && i == n - 1);
      check("crc_valid", crc_valid, CRC_EN && m == 4'b0010 && i == n - 1);
`ifdef TARGET_TX_CRC_EN
      if (m == 4'b0010 && i == n - 1) check("crc_data", crc_data, d);
`else
      check("crc_data_tied", crc_data, 8'h00);
`endif
      prev_sda = exp;
    end
    if (n > 0 && k == n) model_commit(m, d);
  endtask

  initial begin
    logic [3:0] modes [11];
    modes = '{4'h1, 4'h2, 4'h2, 4'h2, 4'h4, 4'h5, 4'h6, 4'h9, 4'h0, 4'h3, 4'hF};

    // Reset state
    rst = 1'b0;
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b1);
    check("rst_sda", sda, 1'b1);
    check("rst_oe", oe, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_crc_valid", crc_valid, 1'b0);
    check("rst_crc_data", crc_data, 8'h00);
    rst = 1'b1;

    tbl[0] = '{4'b0010, 1'b0, 8'hA5, 5'd0, 8, 8'hA5, 1'b1, 1'b1, CRC_EN ? 8'hA5 : 8'h00, CRC_EN};
    tbl[1] = '{4'b0010, 1'b0, 8'h3C, 5'd0, 8, 8'h3C, 1'b1, 1'b1, CRC_EN ? 8'h3C : 8'h00, CRC_EN};
    tbl[2] = '{4'b0100, 1'b0, 8'h00, 5'd0, 2, 8'h40, 1'b1, 1'b1, 8'h00, 1'b0};
    tbl[3] = '{4'b0001, 1'b0, 8'h00, 5'd0, 1, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0};
    tbl[4] = '{4'b1001, 1'b0, 8'h00, 5'd0, 2, 8'h40, 1'b1, 1'b1, 8'h00, 1'b0};
    tbl[5] = '{4'b0101, 1'b0, 8'h00, 5'd0, 4, CRC_EN ? 8'hC0 : 8'hFF, CRC_EN, CRC_EN, 8'h00, 1'b0};
    tbl[6] = '{4'b0110, 1'b0, 8'h00, 5'b10110, 5, CRC_EN ? 8'hB0 : 8'hFF, CRC_EN, CRC_EN, 8'h00, 1'b0};
    tbl[7] = '{4'b0011, 1'b0, 8'h00, 5'd0, 2, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b0};
    tbl[8] = '{4'b0001, 1'b1, 8'h00, 5'd0, 1, 8'h80, 1'b1, 1'b1, 8'h00, 1'b0};

    for (int i = 0; i < 9; i++) begin
      mode = tbl[i].mode;
      pre_value = tbl[i].pre;
      tx_data = tbl[i].data;
      crc_value = tbl[i].crc;
      tx_en = 1'b1;
      for (int j = 0; j < tbl[i].edges; j++) begin
        tick(j % 2 == 0, j % 2 == 1);
        if (j == 0) begin
          tx_data = ~tbl[i].data;
          crc_value = ~tbl[i].crc;
        end
        check("tbl_sda", sda, tbl[i].sda[7-j]);
        check("tbl_oe", oe, tbl[i].oe);
        check("tbl_done", done, tbl[i].done && j == tbl[i].edges - 1);
        check("tbl_crc_valid", crc_valid, tbl[i].crc_vld && j == tbl[i].edges - 1);
        if (tbl[i].crc_vld && j == tbl[i].edges - 1) check("tbl_crc_data", crc_data, tbl[i].crc_out);
        prev_sda = tbl[i].sda[7-j];
      end
      tick(1'b0, 1'b0);
      check("tbl_done_low", done, 1'b0);
      check("tbl_hold_sda", sda, prev_sda);
      if (tbl[i].done) model_commit(tbl[i].mode, tbl[i].data);
    end

    // tx_en dropped after 3 data bits: the byte restarts from its MSB
    do_txn(4'b0010, 1'b0, 8'h96, 5'd0, 3, 0, -1);
    tx_en = 1'b0;
    tick(1'b1, 1'b0);
    check("dis_sda", sda, 1'b1);
    check("dis_oe", oe, 1'b0);
    tick(1'b0, 1'b1);
    check("dis_done", done, 1'b0);
    prev_sda = 1'b1;
    do_txn(4'b0010, 1'b0, 8'h96, 5'd0, -1, 0, -1);

    // Mode switch after 3 data bits
    do_txn(4'b0010, 1'b0, 8'h5A, 5'd0, 3, 0, -1);
    do_txn(4'b0001, 1'b1, 8'h00, 5'd0, -1, 0, -1);
    do_txn(4'b0010, 1'b0, 8'h5A, 5'd0, -1, 0, -1);

    // Coincident pos/neg strobes advance a single bit each
    do_txn(4'b0010, 1'b0, 8'hC3, 5'd0, -1, 0, 2);
    do_txn(4'b0100, 1'b0, 8'h00, 5'd0, -1, 0, 2);

    // Reset mid-byte clears D1/D2 and the byte-pair flag
    do_txn(4'b0010, 1'b0, 8'h80, 5'd0, -1, 0, -1);
    do_txn(4'b0010, 1'b0, 8'h02, 5'd0, -1, 0, -1);
    do_txn(4'b0010, 1'b0, 8'h40, 5'd0, -1, 0, -1);
    do_txn(4'b0010, 1'b0, 8'hFF, 5'd0, 4, 0, -1);
    rst = 1'b0;
    tick(1'b1, 1'b0);
    check("mid_rst_sda", sda, 1'b1);
    check("mid_rst_oe", oe, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_crc_valid", crc_valid, 1'b0);
    rst = 1'b1;
    md1 = 8'd0;
    md2 = 8'd0;
    mfbf = 1'b0;
    prev_sda = 1'b1;
    do_txn(4'b0010, 1'b0, 8'h01, 5'd0, -1, 0, -1);
    do_txn(4'b0100, 1'b0, 8'h00, 5'd0, -1, 0, -1);

    // Randomized back-to-back transactions
    for (int t = 0; t < 120; t++) begin
      do_txn(modes[$urandom_range(10, 0)], 1'($urandom), 8'($urandom), 5'($urandom), -1, 2, -1);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
